kgp_fetch_unit: RTL and testbench

Instruction fetch stage of the KGP_RISC core, sitting directly upstream of decode. It owns the fetch program counter and drives a synchronous instruction memory with one-cycle read latency. It buffers returned words in a 2-entry queue and hands them to decode over a valid/ready handshake. It also accepts branch/jump redirects from execute and reports the PC of the last delivered instruction as `PCValue`.

---
 rtl/kgp_fetch_unit.sv | 128 ++++++++++++
 tb/tb_kgp_fetch_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/kgp_fetch_unit.sv
// KGP_RISC fetch stage: owns the fetch PC, drives a 1-cycle synchronous imem and
// feeds decode through a 2-entry queue. Define FETCH_HALT_DETECT_EN to stop on HALT_WORD.
module kgp_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Ena,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] PCValue,
  output logic        halted
);

`ifdef FETCH_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic        infl_q, infl_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] h_instr_q, h_instr_d, h_pc_q, h_pc_d;
  logic [31:0] t_instr_q, t_instr_d, t_pc_q, t_pc_d;
  logic [31:0] pc_value_q, pc_value_d;

  logic       pop, push, issue, halt_hit;
  logic [2:0] occ;
  logic [1:0] cnt_after;

  always_comb begin
    pop      = (cnt_q != 2'd0) & instr_ready;
    // a redirect kills the response currently returning
    push     = infl_q & ~redirect_valid;
    halt_hit = HALT_EN & push & (imem_rdata == HALT_WORD);
    occ      = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    issue    = ~Reset & (state_q == S_RUN) & Ena & ~redirect_valid & (occ < 3'd2);

    state_d    = state_q;
    fpc_d      = fpc_q;
    infl_pc_d  = infl_pc_q;
    h_instr_d  = h_instr_q;
    h_pc_d     = h_pc_q;
    t_instr_d  = t_instr_q;
    t_pc_d     = t_pc_q;
    pc_value_d = pop ? h_pc_q : pc_value_q;

    if (redirect_valid)
      fpc_d = redirect_pc & 32'hFFFF_FFFC;
    else if (issue)
      fpc_d = fpc_q + 32'd4;

    // a request issued alongside a returning halt word is dropped on arrival
    infl_d = issue & ~halt_hit;
    if (issue) infl_pc_d = fpc_q;

    cnt_after = cnt_q - {1'b0, pop};
    if (pop) begin
      h_instr_d = t_instr_q;
      h_pc_d    = t_pc_q;
    end
    if (push) begin
      if (cnt_after == 2'd0) begin
        h_instr_d = imem_rdata;
        h_pc_d    = infl_pc_q;
      end else begin
        t_instr_d = imem_rdata;
        t_pc_d    = infl_pc_q;
      end
    end
    cnt_d = redirect_valid ? 2'd0 : cnt_after + {1'b0, push};

    case (state_q)
      S_IDLE:  if (halt_hit) state_d = S_HALT; else if (Ena) state_d = S_RUN;
      S_RUN:   if (halt_hit) state_d = S_HALT; else if (!Ena) state_d = S_IDLE;
      S_HALT:  if (redirect_valid) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      fpc_q      <= RESET_PC;
      infl_q     <= 1'b0;
      infl_pc_q  <= 32'h0;
      cnt_q      <= 2'd0;
      h_instr_q  <= 32'h0;
      h_pc_q     <= 32'h0;
      t_instr_q  <= 32'h0;
      t_pc_q     <= 32'h0;
      pc_value_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
      cnt_q      <= cnt_d;
      h_instr_q  <= h_instr_d;
      h_pc_q     <= h_pc_d;
      t_instr_q  <= t_instr_d;
      t_pc_q     <= t_pc_d;
      pc_value_q <= pc_value_d;
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = fpc_q;
  assign instr_valid = (cnt_q != 2'd0);
  assign instr       = h_instr_q;
  assign instr_pc    = h_pc_q;
  assign PCValue     = pc_value_q;
  assign halted      = HALT_EN & (state_q == S_HALT);

endmodule

// File: tb/tb_kgp_fetch_unit.sv
// Directed bench for kgp_fetch_unit; imem model returns addr+1000 one cycle after a request.
module tb_kgp_fetch_unit;
  logic        Clk = 1'b0;
  logic        Reset, Ena, redirect_valid, instr_ready;
  logic [31:0] redirect_pc, imem_rdata, imem_addr, instr, instr_pc, PCValue;
  logic        imem_req, instr_valid, halted;
  logic [31:0] halt_addr = 32'h0000_0001;
  logic [31:0] addrs [2];
  int          total = 0, bad = 0, nreq, found;

  kgp_fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Ena(Ena),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .PCValue(PCValue), .halted(halted)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk)
    imem_rdata <= !imem_req ? 32'hDEAD_BEEF :
                  (imem_addr == halt_addr) ? 32'hFFFF_FFFF : imem_addr + 32'd1000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; Ena = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; #1;
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_pcv", PCValue, 32'h0);

    // IDLE -> RUN, then streaming
    step;
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    step;
    chk("lat_valid0", {31'h0, instr_valid}, 32'h0);
    chk("second_addr", imem_addr, 32'h4);
    step;
    for (int k = 0; k < 4; k++) begin
      chk("str_valid", {31'h0, instr_valid}, 32'h1);
      chk("str_pc", instr_pc, 32'(4 * k));
      chk("str_instr", instr, 32'(4 * k + 1000));
      chk("str_pcv", PCValue, (k == 0) ? 32'h0 : 32'(4 * (k - 1)));
      step;
    end

    // mid-stream reset
    Reset = 1'b1;
    step;
    Reset = 1'b0; instr_ready = 1'b0; #1;
    chk("mrst_valid", {31'h0, instr_valid}, 32'h0);
    chk("mrst_req", {31'h0, imem_req}, 32'h0);
    chk("mrst_instr", instr, 32'h0);
    chk("mrst_ipc", instr_pc, 32'h0);
    chk("mrst_pcv", PCValue, 32'h0);

    // stall: only two requests fit
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      if (imem_req) begin
        if (nreq < 2) addrs[nreq] = imem_addr;
        nreq++;
      end
      step;
    end
    chk("stall_nreq", 32'(nreq), 32'd2);
    chk("stall_a0", addrs[0], 32'h0);
    chk("stall_a1", addrs[1], 32'h4);
    instr_ready = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      chk("rel_valid", {31'h0, instr_valid}, 32'h1);
      chk("rel_pc", instr_pc, 32'(4 * k));
      step;
    end

    // redirect with a queued entry and one in flight
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("rd_noreq", {31'h0, imem_req}, 32'h0);
    chk("rd_busy", {31'h0, instr_valid}, 32'h1);
    step;
    redirect_valid = 1'b0; instr_ready = 1'b1; #1;
    chk("rd_flush", {31'h0, instr_valid}, 32'h0);
    chk("rd_req", {31'h0, imem_req}, 32'h1);
    chk("rd_addr", imem_addr, 32'h100);
    chk("rd_pcv", PCValue, 32'h8);
    step;
    chk("rd_kill", {31'h0, instr_valid}, 32'h0);
    step;
    chk("rd_first_pc", instr_pc, 32'h100);
    chk("rd_first_instr", instr, 32'h4E8);

    // redirect in the same cycle as a pop
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
    chk("rp_noreq", {31'h0, imem_req}, 32'h0);
    step;
    redirect_valid = 1'b0; #1;
    chk("rp_pcv", PCValue, 32'h100);
    chk("rp_flush", {31'h0, instr_valid}, 32'h0);
    chk("rp_addr", imem_addr, 32'h200);
    step; step;
    chk("rp_pc", instr_pc, 32'h200);

    // fetch PC wraps past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step;
    redirect_valid = 1'b0; #1;
    chk("wr_a0", imem_addr, 32'hFFFF_FFFC);
    step;
    chk("wr_a1", imem_addr, 32'h0);
    chk("wr_req", {31'h0, imem_req}, 32'h1);
    step;
    chk("wr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wr_instr", instr, 32'h0000_03E4);
`ifndef FETCH_HALT_DETECT_EN
    chk("nohalt", {31'h0, halted}, 32'h0);
`else
    halt_addr = 32'd12;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step;
    redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 12; i++) begin
      if (instr_valid && instr_pc == 32'd12) begin
        found = 1;
        break;
      end
      step;
    end
    chk("halt_seen", 32'(found), 32'd1);
    chk("halt_instr", instr, 32'hFFFF_FFFF);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    nreq = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      if (imem_req) nreq++;
    end
    chk("halt_noreq", 32'(nreq), 32'd0);
    chk("halt_hold", {31'h0, halted}, 32'h1);
    chk("halt_pcv", PCValue, 32'd12);
    chk("halt_drain", {31'h0, instr_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step;
    redirect_valid = 1'b0; #1;
    chk("hr_halted", {31'h0, halted}, 32'h0);
    chk("hr_req", {31'h0, imem_req}, 32'h1);
    chk("hr_addr", imem_addr, 32'h40);
    step; step;
    chk("hr_pc", instr_pc, 32'h40);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
